// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM states, the
// op_mne opcode map and opcode-class helpers used by the decode logic.
package Definitions;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC     = 4'd3,
      S_MEM_REQ  = 4'd4,
      S_MEM_WAIT = 4'd5,
      S_WB       = 4'd6,
      S_HALT     = 4'd7,
      S_FAULT    = 4'd8
   } ctrl_state;

   // Loads/stores occupy the bottom of the map so the memory class is a range.
   typedef enum logic [3:0] {
      OP_LW  = 4'h0,
      OP_LWL = 4'h1,
      OP_SW  = 4'h2,
      OP_SWL = 4'h3,
      OP_XOR = 4'h4,
      OP_ADD = 4'h5,
      OP_LSR = 4'h6,
      OP_LSL = 4'h7,
      OP_MOV = 4'h8,
      OP_MSK = 4'h9,
      OP_LUT = 4'hA,
      OP_SNE = 4'hB,
      OP_SEQ = 4'hC,
      OP_BOO = 4'hD,
      OP_BOL = 4'hE
   } op_mne;

   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic is_mem(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_LWL) || (op == OP_SW) || (op == OP_SWL);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_SWL);
   endfunction

   function automatic logic is_cmp(input logic [3:0] op);
      return (op == OP_SNE) || (op == OP_SEQ);
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BOO) || (op == OP_BOL);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_perf_counters.sv
// Saturating busy-cycle and retired-instruction counters for the sequencer.
// Only instantiated when CTRL_PERF_CNT_EN is defined.
module ctrl_perf_counters #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             busy,
   input  logic             retire,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         // Both counters stick at all-ones rather than wrapping.
         if (busy && (cycle_count != '1))
            cycle_count <= cycle_count + 1'b1;
         if (retire && (instr_count != '1))
            instr_count <= instr_count + 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/write-back FSM with a
// data-memory req/ack handshake and timeout. CTRL_PERF_CNT_EN adds counters.
module ctrl_sequencer
   import Definitions::*;
#(
   parameter int IW          = 9,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [IW-1:0]    Instr,
   input  logic             Flag,
   input  logic             MemAck,
   output logic             MemReq,
   output logic             MemWrite,
   output logic             IrLoad,
   output logic             PcInc,
   output logic             PcLoad,
   output logic             RegWrite,
   output logic             FlagWrite,
   output logic [3:0]       AluOp,
   output logic             Busy,
   output logic             Done,
   output logic             Fault
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] CycleCount,
   output logic [CNT_W-1:0] InstrCount
`endif
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   ctrl_state      state;
   ctrl_state      state_nxt;
   logic [3:0]     ir_op;
   logic [3:0]     op_cur;
   logic [WCW-1:0] wait_cnt;
   logic           wait_last;
   logic           pc_br;
   logic           pc_br_neg;
   logic           instr_unused;

   assign instr_unused = ^Instr[IW-5:0];

   // In DECODE the new opcode is only in ir_op; AluOp still holds the old one.
   assign op_cur    = (state == S_DECODE) ? ir_op : AluOp;
   assign wait_last = (wait_cnt == WCW'(MEM_TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (Start) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_DECODE;
         S_DECODE:   state_nxt = (ir_op == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (is_mem(AluOp))
               state_nxt = S_MEM_REQ;
            else if (is_cmp(AluOp) || is_branch(AluOp))
               state_nxt = S_FETCH;
            else
               state_nxt = S_WB;
         end
         S_MEM_REQ:  state_nxt = S_MEM_WAIT;
         S_MEM_WAIT: begin
            // An ack in the final allowed cycle beats the timeout.
            if (MemAck)
               state_nxt = is_store(AluOp) ? S_FETCH : S_WB;
            else if (wait_last)
               state_nxt = S_FAULT;
         end
         S_WB:       state_nxt = S_FETCH;
         S_HALT:     if (Start) state_nxt = S_FETCH;
         S_FAULT:    state_nxt = S_FAULT;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they are clean in-cycle.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= S_IDLE;
         ir_op     <= OP_LW;
         AluOp     <= OP_LW;
         wait_cnt  <= '0;
         IrLoad    <= 1'b0;
         PcInc     <= 1'b0;
         RegWrite  <= 1'b0;
         FlagWrite <= 1'b0;
         MemReq    <= 1'b0;
         MemWrite  <= 1'b0;
         pc_br     <= 1'b0;
         pc_br_neg <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Fault     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH)
            ir_op <= Instr[IW-1:IW-4];
         if (state == S_DECODE)
            AluOp <= ir_op;
         wait_cnt <= (state == S_MEM_WAIT) ? wait_cnt + 1'b1 : '0;

         IrLoad    <= (state_nxt == S_FETCH);
         PcInc     <= (state_nxt == S_FETCH);
         RegWrite  <= (state_nxt == S_WB);
         FlagWrite <= (state_nxt == S_EXEC) && is_cmp(op_cur);
         pc_br     <= (state_nxt == S_EXEC) && is_branch(op_cur);
         pc_br_neg <= (op_cur == OP_BOL);
         MemReq    <= (state_nxt == S_MEM_REQ) || (state_nxt == S_MEM_WAIT);
         MemWrite  <= ((state_nxt == S_MEM_REQ) || (state_nxt == S_MEM_WAIT)) && is_store(op_cur);
         Busy      <= !((state_nxt == S_IDLE) || (state_nxt == S_HALT) || (state_nxt == S_FAULT));
         Done      <= (state_nxt == S_HALT);
         Fault     <= (state_nxt == S_FAULT);
      end
   end

   // Branch target select follows the live flag while in EXEC.
   assign PcLoad = pc_br & (Flag ^ pc_br_neg);

`ifdef CTRL_PERF_CNT_EN
   logic retire;

   assign retire = ((state_nxt == S_FETCH) &&
                    ((state == S_EXEC) || (state == S_MEM_WAIT) || (state == S_WB))) ||
                   ((state == S_DECODE) && (state_nxt == S_HALT));

   ctrl_perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .Clk         (Clk),
      .Reset       (Reset),
      .busy        (Busy),
      .retire      (retire),
      .cycle_count (CycleCount),
      .instr_count (InstrCount)
   );
`endif

endmodule
